// File: rtl/pc_trace_pkg.sv
// Shared types and constants for the PC trace buffer.
package pc_trace_pkg;

  localparam int AW_DEF = 32;
  localparam int OVF_W  = 16;
  localparam logic [OVF_W-1:0] OVF_MAX = 16'hFFFF;

  typedef logic [AW_DEF-1:0] trace_addr_t;

endpackage

// File: rtl/pc_trace_fifo.sv
// First-word-fall-through circular FIFO; pointers carry a wrap bit so full and
// empty are told apart without a separate flag.
module pc_trace_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 32,
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic          wb_clk,
  input  logic          wb_rst_n,
  input  logic          push_i,
  input  logic [W-1:0]  data_i,
  input  logic          pop_i,
  output logic [W-1:0]  data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  localparam logic [CW-1:0] FULL_X = {1'b1, {(CW-1){1'b0}}};

  logic [CW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [W-1:0]  mem_q [DEPTH];
  logic          do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = ((wr_q ^ rd_q) == FULL_X);
  assign count_o = wr_q - rd_q;
  assign data_o  = mem_q[rd_q[CW-2:0]];
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (push_i) wr_d = wr_q + CW'(1);
    if (do_pop) rd_d = rd_q + CW'(1);
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage is intentionally not reset; a push into a full FIFO only happens
  // alongside a pop, so the slot it overwrites has already been read out.
  always_ff @(posedge wb_clk) begin
    if (push_i) mem_q[wr_q[CW-2:0]] <= data_i;
  end

endmodule

// File: rtl/pc_trace_buffer.sv
// Dedups the committed fetch-address stream into a FWFT FIFO, counts entries
// dropped on full, and flags a tight self-loop (end-of-test idiom).
module pc_trace_buffer
  import pc_trace_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int AW         = 32,
  parameter int LOOP_LIMIT = 8,
  localparam int CW        = $clog2(DEPTH) + 1
) (
  input  logic             wb_clk,
  input  logic             wb_rst_n,
  input  logic [AW-1:0]    i_pc_adr,
  input  logic             i_pc_vld,
  output logic [AW-1:0]    o_tr_data,
  output logic             o_tr_vld,
  input  logic             i_tr_rdy,
  output logic [CW-1:0]    o_count,
  output logic [OVF_W-1:0] o_ovf_cnt,
  output logic             o_loop
);

  localparam int RW = $clog2(LOOP_LIMIT + 1);
  localparam logic [RW-1:0] REP_MAX = RW'(LOOP_LIMIT);

  logic [AW-1:0]    last_pc_q, last_pc_d;
  logic             last_ok_q, last_ok_d;
  logic [RW-1:0]    rep_q, rep_d;
  logic             loop_q, loop_d;
  logic [OVF_W-1:0] ovf_q, ovf_d;

  logic is_new, pop, push_ok, full, empty;

  assign is_new  = i_pc_vld & (~last_ok_q | (i_pc_adr != last_pc_q));
  assign pop     = o_tr_vld & i_tr_rdy;
  assign push_ok = is_new & (~full | pop);

  pc_trace_fifo #(.DEPTH(DEPTH), .W(AW)) u_fifo (
    .wb_clk  (wb_clk),
    .wb_rst_n(wb_rst_n),
    .push_i  (push_ok),
    .data_i  (i_pc_adr),
    .pop_i   (pop),
    .data_o  (o_tr_data),
    .full_o  (full),
    .empty_o (empty),
    .count_o (o_count)
  );

  always_comb begin
    last_pc_d = last_pc_q;
    last_ok_d = last_ok_q;
    rep_d     = rep_q;
    loop_d    = loop_q;
    ovf_d     = ovf_q;
    if (is_new) begin
      // last_pc tracks even dropped entries so dedup never re-admits a repeat
      last_pc_d = i_pc_adr;
      last_ok_d = 1'b1;
      rep_d     = RW'(1);
      loop_d    = 1'b0;
    end else if (i_pc_vld) begin
      if (rep_q < REP_MAX) rep_d = rep_q + RW'(1);
      if (rep_d == REP_MAX) loop_d = 1'b1;
    end
    if (is_new & ~push_ok & (ovf_q != OVF_MAX)) ovf_d = ovf_q + OVF_W'(1);
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      last_pc_q <= '0;
      last_ok_q <= 1'b0;
      rep_q     <= '0;
      loop_q    <= 1'b0;
      ovf_q     <= '0;
    end else begin
      last_pc_q <= last_pc_d;
      last_ok_q <= last_ok_d;
      rep_q     <= rep_d;
      loop_q    <= loop_d;
      ovf_q     <= ovf_d;
    end
  end

  assign o_tr_vld  = ~empty;
  assign o_ovf_cnt = ovf_q;
  assign o_loop    = loop_q;

endmodule

// File: tb/tb_pc_trace_buffer.sv
// Randomised bench for pc_trace_buffer against a queue-based reference model.
module tb_pc_trace_buffer;

  localparam int DEPTH = 16;
  localparam int AW    = 32;
  localparam int LL    = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          wb_clk = 1'b0;
  logic          wb_rst_n = 1'b0;
  logic [AW-1:0] i_pc_adr = '0;
  logic          i_pc_vld = 1'b0;
  logic          i_tr_rdy = 1'b0;
  logic [AW-1:0] o_tr_data;
  logic          o_tr_vld;
  logic [CW-1:0] o_count;
  logic [15:0]   o_ovf_cnt;
  logic          o_loop;

  always #5 wb_clk = ~wb_clk;

  pc_trace_buffer #(.DEPTH(DEPTH), .AW(AW), .LOOP_LIMIT(LL)) dut (
    .wb_clk   (wb_clk),
    .wb_rst_n (wb_rst_n),
    .i_pc_adr (i_pc_adr),
    .i_pc_vld (i_pc_vld),
    .o_tr_data(o_tr_data),
    .o_tr_vld (o_tr_vld),
    .i_tr_rdy (i_tr_rdy),
    .o_count  (o_count),
    .o_ovf_cnt(o_ovf_cnt),
    .o_loop   (o_loop)
  );

  int n_chk = 0;
  int n_fail = 0;

  // reference model: contents of the trace as a plain queue
  logic [AW-1:0] q[$];
  logic [AW-1:0] m_last_pc;
  bit            m_last_ok;
  int            m_rep;
  bit            m_loop;
  int            m_ovf;

  function automatic void m_reset();
    q.delete();
    m_last_pc = '0;
    m_last_ok = 1'b0;
    m_rep     = 0;
    m_loop    = 1'b0;
    m_ovf     = 0;
  endfunction

  function automatic void m_step(logic v, logic [AW-1:0] a, logic r);
    int sz;
    bit pop, push;
    sz   = q.size();
    pop  = (sz > 0) && r;
    push = 1'b0;
    if (v) begin
      if (!m_last_ok || a != m_last_pc) begin
        m_last_pc = a;
        m_last_ok = 1'b1;
        m_rep     = 1;
        m_loop    = 1'b0;
        push      = 1'b1;
      end else begin
        if (m_rep < LL) m_rep++;
        if (m_rep == LL) m_loop = 1'b1;
      end
    end
    if (pop) void'(q.pop_front());
    if (push) begin
      if (sz < DEPTH || pop) q.push_back(a);
      else if (m_ovf < 65535) m_ovf++;
    end
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic cyc(input logic v, input logic [AW-1:0] a, input logic r);
    i_pc_vld = v;
    i_pc_adr = a;
    i_tr_rdy = r;
    @(posedge wb_clk);
    if (wb_rst_n) m_step(v, a, r);
    @(negedge wb_clk);
  endtask

  task automatic do_reset();
    #2 wb_rst_n = 1'b0;
    m_reset();
    #1;
    chk("rst_vld",   32'(o_tr_vld),  32'd0);
    chk("rst_count", 32'(o_count),   32'd0);
    chk("rst_ovf",   32'(o_ovf_cnt), 32'd0);
    chk("rst_loop",  32'(o_loop),    32'd0);
    @(negedge wb_clk);
    wb_rst_n = 1'b1;
  endtask

  task automatic compare();
    chk("m_vld",   32'(o_tr_vld),  32'(q.size() != 0));
    chk("m_count", 32'(o_count),   32'(q.size()));
    chk("m_ovf",   32'(o_ovf_cnt), 32'(m_ovf));
    chk("m_loop",  32'(o_loop),    32'(m_loop));
    if (q.size() != 0) chk("m_data", o_tr_data, q[0]);
  endtask

  task automatic stimulus();
    logic [AW-1:0] a;
    m_reset();
    repeat (2) @(negedge wb_clk);
    wb_rst_n = 1'b1;
    chk("init_vld", 32'(o_tr_vld), 32'd0);
    chk("init_cnt", 32'(o_count),  32'd0);

    // straight-through stream
    cyc(1'b1, 32'h00, 1'b1); chk("s0_data", o_tr_data, 32'h00); chk("s0_cnt", 32'(o_count), 32'd1);
    cyc(1'b1, 32'h04, 1'b1); chk("s1_data", o_tr_data, 32'h04); chk("s1_cnt", 32'(o_count), 32'd1);
    cyc(1'b1, 32'h08, 1'b1); chk("s2_data", o_tr_data, 32'h08); chk("s2_cnt", 32'(o_count), 32'd1);
    cyc(1'b0, 32'h00, 1'b1); chk("s3_vld",  32'(o_tr_vld), 32'd0);

    // dedup
    repeat (3) cyc(1'b1, 32'h10, 1'b0);
    cyc(1'b1, 32'h14, 1'b0);
    chk("dd_cnt",  32'(o_count), 32'd2);
    chk("dd_loop", 32'(o_loop),  32'd0);
    chk("dd_h0",   o_tr_data,    32'h10);
    cyc(1'b0, '0, 1'b1); chk("dd_h1", o_tr_data, 32'h14);
    cyc(1'b0, '0, 1'b1); chk("dd_empty", 32'(o_tr_vld), 32'd0);

    // self-loop detection
    for (int i = 0; i < LL; i++) begin
      cyc(1'b1, 32'h80, 1'b0);
      if (i == LL - 2) chk("lp_before", 32'(o_loop), 32'd0);
    end
    chk("lp_set", 32'(o_loop),  32'd1);
    chk("lp_cnt", 32'(o_count), 32'd1);
    cyc(1'b1, 32'h84, 1'b0);
    chk("lp_clr", 32'(o_loop),  32'd0);
    chk("lp_cnt2", 32'(o_count), 32'd2);
    repeat (2) cyc(1'b0, '0, 1'b1);

    // overflow and ordered drain
    do_reset();
    for (int i = 0; i < 20; i++) cyc(1'b1, 32'h1000 + 32'(4 * i), 1'b0);
    chk("of_cnt", 32'(o_count),   32'd16);
    chk("of_ovf", 32'(o_ovf_cnt), 32'd4);
    for (int i = 0; i < 16; i++) begin
      chk("of_drain", o_tr_data, 32'h1000 + 32'(4 * i));
      cyc(1'b0, '0, 1'b1);
    end
    chk("of_empty", 32'(o_tr_vld), 32'd0);

    // full with simultaneous pop and push, then reset mid-drain
    for (int i = 0; i < 20; i++) cyc(1'b1, 32'h3000 + 32'(4 * i), 1'b0);
    chk("fp_ovf0", 32'(o_ovf_cnt), 32'd8);
    cyc(1'b1, 32'h4000, 1'b1);
    chk("fp_cnt",  32'(o_count),   32'd16);
    chk("fp_ovf",  32'(o_ovf_cnt), 32'd8);
    chk("fp_head", o_tr_data,      32'h3004);
    repeat (LL - 1) cyc(1'b1, 32'h4000, 1'b1);
    chk("fp_loop", 32'(o_loop), 32'd1);
    do_reset();
    cyc(1'b1, 32'h4000, 1'b0);
    chk("pr_new_cnt",  32'(o_count), 32'd1);
    chk("pr_new_data", o_tr_data,    32'h4000);
    repeat (2) cyc(1'b0, '0, 1'b1);

    // randomised traffic
    for (int i = 0; i < 3000; i++) begin
      int rp;
      rp = ((i / 500) % 2 == 0) ? 20 : 80;
      if ((i % 200) < 12) a = 32'h500;
      else a = 32'h100 + 32'(4 * $urandom_range(0, 3));
      cyc($urandom_range(0, 3) != 0, a, $urandom_range(0, 99) < rp);
      if ($urandom_range(0, 999) == 0) do_reset();
    end
  endtask

  initial begin
    fork
      stimulus();
      forever begin
        @(negedge wb_clk);
        compare();
      end
    join_any
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_trace_buffer.md
# pc_trace_buffer

Downstream trace stage for the servant simulation harness. It samples the committed instruction-fetch address stream (`pc_adr`/`pc_vld`) and drops consecutive duplicate addresses. Unique addresses go into a first-word-fall-through circular FIFO, which a testbench monitor or trace dumper drains over a valid/ready port. It also counts dropped entries and flags a tight self-loop, which is the servant end-of-test idiom (`j .`).

## Interface
- `DEPTH`, 16, FIFO entries; power of two, ≥2.
- `AW`, 32, address width.
- `LOOP_LIMIT`, 8, consecutive identical `pc_vld` samples that raise `o_loop`; ≥2.
- `wb_clk`  in  1  sole clock; all state on its rising edge.
- `wb_rst_n`  in  1  reset, asynchronous assert, active-low; release is synchronous to `wb_clk` by the integrator.
- `i_pc_adr`  in  AW  fetch address from the core's memory port.
- `i_pc_vld`  in  1  single-cycle strobe; address is valid while high.
- `o_tr_data`  out  AW  head-of-FIFO address.
- `o_tr_vld`  out  1  FIFO non-empty.
- `i_tr_rdy`  in  1  consumer pops the head when `o_tr_vld & i_tr_rdy`.
- `o_count`  out  $clog2(DEPTH)+1  current occupancy.
- `o_ovf_cnt`  out  16  saturating count of entries dropped because the FIFO was full.
- `o_loop`  out  1  self-loop detected.

## Operation
- State: `last_pc` (AW), `last_ok` (1), `rep_cnt` (saturating at LOOP_LIMIT), `wr_ptr`/`rd_ptr` ($clog2(DEPTH)+1 bits, with a wrap bit), storage array, `ovf_cnt`.
- Classify each cycle with `i_pc_vld=1`:
  - NEW when `!last_ok` or `i_pc_adr != last_pc`. Update `last_pc`, set `last_ok=1`, `rep_cnt=1`, clear `o_loop`, request a push.
  - REPEAT otherwise. No push. `rep_cnt` increments and saturates at LOOP_LIMIT. `o_loop` sets when `rep_cnt` reaches LOOP_LIMIT.
- Push and pop resolution:
  - pop = `o_tr_vld & i_tr_rdy`.
  - A push is accepted if `count < DEPTH` or a pop happens in the same cycle.
  - A rejected push increments `ovf_cnt`, which saturates at 16'hFFFF. `last_pc` still updates, so dedup stays exact.
  - Simultaneous push and pop keeps `count` unchanged.
- Full is `wr_ptr ^ rd_ptr == {1'b1, 0...}`; empty is pointers equal. Pointers wrap modulo 2·DEPTH.
- `o_tr_data` = `mem[rd_ptr]` (combinational read of registered storage). When empty it is don't-care, and benches must not check it.
- `o_tr_data` is stable while `o_tr_vld & !i_tr_rdy`.
- Reset (async, `wb_rst_n=0`): pointers=0, `last_ok=0`, `last_pc=0`, `rep_cnt=0`, `ovf_cnt=0`, `o_loop=0`. As a result `o_tr_vld=0`, `o_count=0`, and `o_ovf_cnt=0`. Storage contents are not reset. Reset mid-stream discards all entries, and the first post-reset strobe is always NEW.

## Timing
- Push latency is 1 cycle. A NEW sample at edge k gives `o_tr_vld=1` with that address from edge k onward (registered), even when the FIFO was empty.
- A pop at edge k advances the head at that edge. Back-to-back pops at 1 per cycle are supported.
- `o_loop` rises at the edge of the LOOP_LIMIT-th identical strobe. It falls at the edge of the next NEW strobe or at reset.
- `o_count` and `o_ovf_cnt` are registered and update at the same edge as the push or pop.
- Idle cycles (`i_pc_vld=0`) change nothing except pops.

## Structure
- Package `pc_trace_pkg` holds the `trace_addr_t` typedef (AW-bit logic), `OVF_W=16`, and the `OVF_MAX` constant.
- One sub-module, `pc_trace_fifo`: a parameterised FWFT circular FIFO with push/pop/full/empty/count. The top level contains the dedup, loop detector, and overflow counter.

## Test plan
- Strobes 0x00,0x04,0x08 with `i_tr_rdy=1` -> `o_tr_data` shows 0x00,0x04,0x08 on consecutive cycles; `o_count` peaks at 1.
- Strobes 0x10,0x10,0x10,0x14 -> exactly two entries (0x10, 0x14); `o_loop` stays 0.
- 8 strobes of 0x80 with DEPTH=16 and LOOP_LIMIT=8 -> one entry; `o_loop`=1 at the 8th edge; a strobe at 0x84 clears it.
- `i_tr_rdy=0` with 20 distinct addresses -> `o_count`=16, `o_ovf_cnt`=4; draining yields the first 16 addresses in order.
- Full FIFO with a simultaneous pop and NEW push -> `o_count` stays 16 and `o_ovf_cnt` does not change; assert `wb_rst_n=0` mid-drain -> `o_tr_vld=0`, `o_count=0`, `o_ovf_cnt=0`, `o_loop=0` immediately, without waiting for a clock edge.
